cordic_sched: RTL and testbench

Round-robin scheduler that shares one iterative 16-iteration CORDIC engine between `NUM_REQ` requesters. It accepts one operand set at a time with a valid/ready handshake, sequences the engine's `start`/`busy` protocol, and captures the 21-bit results. It returns them on a single response port tagged with the requester index. It sits between the client blocks (rotation/vectoring users) and the `cordic` engine instance, which remains a separate instance driven by this block.

---
 rtl/cordic_pkg.sv | 16 +
 rtl/rr_arbiter.sv | 34 +++
 rtl/cordic_sched.sv | 167 ++++++++++++++++
 tb/tb_cordic_sched.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/cordic_pkg.sv
// rtl/cordic_pkg.sv - shared widths, FSM states and calc_mode codes for the CORDIC scheduler
package cordic_pkg;
    localparam int CORDIC_IN_W  = 20;
    localparam int CORDIC_OUT_W = 21;

    localparam logic CALC_MODE_ROTATE = 1'b0;
    localparam logic CALC_MODE_VECTOR = 1'b1;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT,
        ST_RUN,
        ST_RESP
    } sched_state_t;
endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - combinational round-robin pick: first set request at or after the pointer
module rr_arbiter #(
    parameter int NUM_REQ = 4
) (
    input  logic [NUM_REQ-1:0]         i_req,
    input  logic [$clog2(NUM_REQ)-1:0] i_ptr,
    output logic [NUM_REQ-1:0]         o_gnt,
    output logic [$clog2(NUM_REQ)-1:0] o_idx,
    output logic                       o_any
);
    localparam int IDX_W = $clog2(NUM_REQ);

    always_comb begin
        int               j;
        logic [IDX_W-1:0] w_pos;
        o_gnt = '0;
        o_idx = '0;
        o_any = 1'b0;
        j     = 0;
        w_pos = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            j = int'(i_ptr) + k;
            if (j >= NUM_REQ) begin
                j = j - NUM_REQ;
            end
            w_pos = IDX_W'(j);
            if (!o_any && i_req[w_pos]) begin
                o_any        = 1'b1;
                o_gnt[w_pos] = 1'b1;
                o_idx        = w_pos;
            end
        end
    end
endmodule

// File: rtl/cordic_sched.sv
// rtl/cordic_sched.sv - round-robin scheduler sharing one iterative CORDIC engine between requesters
// Optional RUN-state watchdog is built when CORDIC_SCHED_TIMEOUT_EN is defined.
module cordic_sched
    import cordic_pkg::*;
#(
    parameter int NUM_REQ     = 4,
    parameter int TIMEOUT_CYC = 32
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic [NUM_REQ-1:0]             req_valid,
    input  logic [NUM_REQ-1:0]             req_mode,
    input  logic [CORDIC_IN_W*NUM_REQ-1:0] req_x0,
    input  logic [CORDIC_IN_W*NUM_REQ-1:0] req_y0,
    input  logic [CORDIC_IN_W*NUM_REQ-1:0] req_z0,
    output logic [NUM_REQ-1:0]             req_ready,
    output logic                           rsp_valid,
    input  logic                           rsp_ready,
    output logic [$clog2(NUM_REQ)-1:0]     rsp_id,
    output logic [CORDIC_OUT_W-1:0]        rsp_x,
    output logic [CORDIC_OUT_W-1:0]        rsp_y,
    output logic [CORDIC_OUT_W-1:0]        rsp_z,
    output logic                           rsp_err,
    output logic                           eng_start,
    output logic                           eng_mode,
    output logic [CORDIC_IN_W-1:0]         eng_x0,
    output logic [CORDIC_IN_W-1:0]         eng_y0,
    output logic [CORDIC_IN_W-1:0]         eng_z0,
    input  logic                           eng_busy,
    input  logic [CORDIC_OUT_W-1:0]        eng_x,
    input  logic [CORDIC_OUT_W-1:0]        eng_y,
    input  logic [CORDIC_OUT_W-1:0]        eng_z
);
    localparam int IDX_W = $clog2(NUM_REQ);

    if (NUM_REQ < 2 || NUM_REQ > 8) begin : g_bad_num_req
        $error("NUM_REQ must be in 2..8");
    end
    if (TIMEOUT_CYC < 1) begin : g_bad_timeout
        $error("TIMEOUT_CYC must be at least 1");
    end

    sched_state_t            r_state;
    logic [IDX_W-1:0]        r_ptr;
    logic [IDX_W-1:0]        r_gid;
    logic [NUM_REQ-1:0]      w_gnt;
    logic [IDX_W-1:0]        w_gnt_idx;
    logic                    w_any;
    logic [IDX_W-1:0]        w_ptr_next;
    logic                    w_mode_sel;
    logic [CORDIC_IN_W-1:0]  w_x0_sel;
    logic [CORDIC_IN_W-1:0]  w_y0_sel;
    logic [CORDIC_IN_W-1:0]  w_z0_sel;

    rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
        .i_req (req_valid),
        .i_ptr (r_ptr),
        .o_gnt (w_gnt),
        .o_idx (w_gnt_idx),
        .o_any (w_any)
    );

    // Grant is only offered while idle and out of reset, so all outputs read 0 during reset.
    assign req_ready  = (r_state == ST_IDLE && reset) ? w_gnt : '0;
    assign w_ptr_next = (w_gnt_idx == IDX_W'(NUM_REQ - 1)) ? '0 : w_gnt_idx + IDX_W'(1);

    always_comb begin
        w_mode_sel = 1'b0;
        w_x0_sel   = '0;
        w_y0_sel   = '0;
        w_z0_sel   = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (w_gnt_idx == IDX_W'(i)) begin
                w_mode_sel = req_mode[i];
                w_x0_sel   = req_x0[i*CORDIC_IN_W +: CORDIC_IN_W];
                w_y0_sel   = req_y0[i*CORDIC_IN_W +: CORDIC_IN_W];
                w_z0_sel   = req_z0[i*CORDIC_IN_W +: CORDIC_IN_W];
            end
        end
    end

`ifdef CORDIC_SCHED_TIMEOUT_EN
    localparam int TMO_W = $clog2(TIMEOUT_CYC + 1);
    logic [TMO_W-1:0] r_tmo_cnt;
`else
    assign rsp_err = 1'b0;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state   <= ST_IDLE;
            r_ptr     <= '0;
            r_gid     <= '0;
            eng_start <= 1'b0;
            eng_mode  <= CALC_MODE_ROTATE;
            eng_x0    <= '0;
            eng_y0    <= '0;
            eng_z0    <= '0;
            rsp_valid <= 1'b0;
            rsp_id    <= '0;
            rsp_x     <= '0;
            rsp_y     <= '0;
            rsp_z     <= '0;
`ifdef CORDIC_SCHED_TIMEOUT_EN
            rsp_err   <= 1'b0;
            r_tmo_cnt <= '0;
`endif
        end else begin
            eng_start <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_any) begin
                        eng_mode  <= w_mode_sel;
                        eng_x0    <= w_x0_sel;
                        eng_y0    <= w_y0_sel;
                        eng_z0    <= w_z0_sel;
                        eng_start <= 1'b1;
                        r_gid     <= w_gnt_idx;
                        r_ptr     <= w_ptr_next;
                        r_state   <= ST_ISSUE;
                    end
                end
                ST_ISSUE: r_state <= ST_WAIT;
                // busy from the engine is still stale here (it powers up high), so it is not looked at.
                ST_WAIT: begin
                    r_state <= ST_RUN;
`ifdef CORDIC_SCHED_TIMEOUT_EN
                    r_tmo_cnt <= '0;
`endif
                end
                ST_RUN: begin
                    if (!eng_busy) begin
                        rsp_x     <= eng_x;
                        rsp_y     <= eng_y;
                        rsp_z     <= eng_z;
                        rsp_id    <= r_gid;
                        rsp_valid <= 1'b1;
                        r_state   <= ST_RESP;
                    end
`ifdef CORDIC_SCHED_TIMEOUT_EN
                    else if (r_tmo_cnt == TMO_W'(TIMEOUT_CYC - 1)) begin
                        rsp_x     <= '0;
                        rsp_y     <= '0;
                        rsp_z     <= '0;
                        rsp_id    <= r_gid;
                        rsp_err   <= 1'b1;
                        rsp_valid <= 1'b1;
                        r_state   <= ST_RESP;
                    end else begin
                        r_tmo_cnt <= r_tmo_cnt + 1'b1;
                    end
`endif
                end
                ST_RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
`ifdef CORDIC_SCHED_TIMEOUT_EN
                        rsp_err   <= 1'b0;
`endif
                        r_state   <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_cordic_sched.sv
// tb/tb_cordic_sched.sv - self-checking bench for cordic_sched with a behavioural 16-iteration engine model
`timescale 1ns/1ps
module tb_cordic_sched;
    import cordic_pkg::*;

    localparam int NR  = 4;
    localparam int TMO = 32;
    localparam int LAT = 19;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                      reset;
    logic [NR-1:0]             req_valid, req_mode, req_ready;
    logic [CORDIC_IN_W*NR-1:0] req_x0, req_y0, req_z0;
    logic                      rsp_valid, rsp_ready, rsp_err;
    logic [1:0]                rsp_id;
    logic [CORDIC_OUT_W-1:0]   rsp_x, rsp_y, rsp_z;
    logic                      eng_start, eng_mode, eng_busy;
    logic [CORDIC_IN_W-1:0]    eng_x0, eng_y0, eng_z0;
    logic [CORDIC_OUT_W-1:0]   eng_x, eng_y, eng_z;

    cordic_sched #(.NUM_REQ(NR), .TIMEOUT_CYC(TMO)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_mode(req_mode),
        .req_x0(req_x0), .req_y0(req_y0), .req_z0(req_z0),
        .req_ready(req_ready),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
        .rsp_x(rsp_x), .rsp_y(rsp_y), .rsp_z(rsp_z), .rsp_err(rsp_err),
        .eng_start(eng_start), .eng_mode(eng_mode),
        .eng_x0(eng_x0), .eng_y0(eng_y0), .eng_z0(eng_z0),
        .eng_busy(eng_busy), .eng_x(eng_x), .eng_y(eng_y), .eng_z(eng_z)
    );

    // Stand-in engine result: any deterministic function of the operands will do.
    function automatic logic [62:0] eng_fn(input logic mode, input logic [19:0] x0,
                                           input logic [19:0] y0, input logic [19:0] z0);
        logic [20:0] sx, sy, sz;
        sx = {x0[19], x0};
        sy = {y0[19], y0};
        sz = {z0[19], z0};
        return {sx + sy, sy - sx, (mode == CALC_MODE_VECTOR) ? ~sz : sz};
    endfunction

    // Engine model: busy from power-up, 16 busy edges after sampling start, garbage outputs while busy.
    logic        eng_rst_n;
    bit          stuck;
    int          eng_cnt;
    always @(posedge clk or negedge eng_rst_n) begin
        if (!eng_rst_n) begin
            eng_busy <= 1'b1;
            eng_cnt  <= 0;
            {eng_x, eng_y, eng_z} <= '0;
        end else if (eng_start) begin
            eng_busy <= 1'b1;
            eng_cnt  <= 16;
            {eng_x, eng_y, eng_z} <= {eng_fn(eng_mode, eng_x0, eng_y0, eng_z0) ^ 63'h2AAA_AAAA_AAAA_AAAA};
        end else if (eng_busy) begin
            if (eng_cnt == 1 && !stuck) begin
                eng_busy <= 1'b0;
                {eng_x, eng_y, eng_z} <= eng_fn(eng_mode, eng_x0, eng_y0, eng_z0);
            end else begin
                eng_cnt <= eng_cnt - 1;
                eng_x   <= 21'($urandom);
                eng_y   <= 21'($urandom);
                eng_z   <= 21'($urandom);
            end
        end
    end

    int checks = 0;
    int errors = 0;
    int m_ptr  = 0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic int rr_pick(input logic [NR-1:0] mask, input int ptr);
        for (int k = 0; k < NR; k++) begin
            if (mask[(ptr + k) % NR]) return (ptr + k) % NR;
        end
        return -1;
    endfunction

    task automatic scramble_ops();
        for (int i = 0; i < NR; i++) begin
            req_x0[i*20 +: 20] = 20'($urandom);
            req_y0[i*20 +: 20] = 20'($urandom);
            req_z0[i*20 +: 20] = 20'($urandom);
        end
        req_mode = NR'($urandom);
    endtask

    // Called at a negedge with the DUT idle; returns at the negedge of the first idle cycle after the handshake.
    task automatic run_txn(input logic [NR-1:0] mask, input int g, input logic mode,
                           input logic [19:0] x0, input logic [19:0] y0, input logic [19:0] z0,
                           input int delay, input string tag);
        logic [62:0] exp_r, held;
        int          k;
        bit          rdy_seen, extra_start, ops_moved, unstable;
        exp_r = eng_fn(mode, x0, y0, z0);
        scramble_ops();
        req_x0[g*20 +: 20] = x0;
        req_y0[g*20 +: 20] = y0;
        req_z0[g*20 +: 20] = z0;
        req_mode[g]        = mode;
        req_valid          = mask;
        #1;
        chk({tag, " grant"}, 128'(req_ready), 128'(NR'(1) << g));
        @(negedge clk);
        m_ptr = (g + 1) % NR;
        chk({tag, " start"}, 128'(eng_start), 128'(1));
        chk({tag, " operands"}, 128'({eng_mode, eng_x0, eng_y0, eng_z0}), 128'({mode, x0, y0, z0}));
        rdy_seen = 0; extra_start = 0; ops_moved = 0;
        k = 1;
        while (!rsp_valid && k < LAT + 10) begin
            scramble_ops();
            @(negedge clk);
            k++;
            if (req_ready != 0) rdy_seen = 1;
            if (eng_start) extra_start = 1;
            if ({eng_mode, eng_x0, eng_y0, eng_z0} != {mode, x0, y0, z0}) ops_moved = 1;
        end
        chk({tag, " latency"}, 128'(k), 128'(LAT));
        chk({tag, " busy-ready"}, 128'({rdy_seen, extra_start, ops_moved}), 128'(0));
        chk({tag, " rsp"}, 128'({rsp_id, rsp_x, rsp_y, rsp_z, rsp_err}), 128'({2'(g), exp_r, 1'b0}));
        held = {rsp_x, rsp_y, rsp_z};
        unstable = 0;
        for (int d = 0; d < delay; d++) begin
            @(negedge clk);
            if (!rsp_valid || {rsp_x, rsp_y, rsp_z} != held || rsp_id != 2'(g) || req_ready != 0) unstable = 1;
        end
        if (delay > 0) chk({tag, " backpressure hold"}, 128'(unstable), 128'(0));
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        chk({tag, " rsp drop"}, 128'(rsp_valid), 128'(0));
        chk({tag, " next grant"}, 128'(req_ready), 128'(NR'(1) << rr_pick(mask, m_ptr)));
    endtask

    task automatic reset_dut();
        reset     = 1'b0;
        req_valid = '0;
        rsp_ready = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        m_ptr = 0;
        @(negedge clk);
    endtask

    typedef struct {
        logic [NR-1:0] mask;
        int            grant;
        logic          mode;
        logic [19:0]   x0, y0, z0;
        int            delay;
    } vec_t;

    vec_t vecs[6];
    int   fair_order[5];

    initial begin
        int          k, g;
        bit          seen;
        logic [NR-1:0] mask;
        vecs[0] = '{4'b0100, 2, 1'b0, 20'h04DBA, 20'h00000, 20'h01000, 0};
        vecs[1] = '{4'b0011, 0, 1'b1, 20'hFFFFF, 20'h80000, 20'h7FFFF, 10};
        vecs[2] = '{4'b1010, 1, 1'b0, 20'h7FFFF, 20'h7FFFF, 20'h80000, 1};
        vecs[3] = '{4'b1010, 3, 1'b1, 20'h80000, 20'h00001, 20'h12345, 0};
        vecs[4] = '{4'b1000, 3, 1'b0, 20'h00000, 20'h00000, 20'h00000, 2};
        vecs[5] = '{4'b0001, 0, 1'b1, 20'hABCDE, 20'h13579, 20'h2468A, 0};
        fair_order = '{0, 1, 2, 3, 0};

        reset = 1'b0; eng_rst_n = 1'b0; stuck = 0;
        req_valid = '1; rsp_ready = 1'b0;
        req_x0 = '0; req_y0 = '0; req_z0 = '0; req_mode = '0;
        #1;
        chk("reset eng outs", 128'({eng_start, eng_mode, eng_x0, eng_y0, eng_z0}), 128'(0));
        chk("reset rsp outs", 128'({rsp_valid, rsp_id, rsp_x, rsp_y, rsp_z, rsp_err}), 128'(0));
        chk("reset req_ready", 128'(req_ready), 128'(0));
        repeat (3) @(negedge clk);
        eng_rst_n = 1'b1;
        reset     = 1'b1;
        req_valid = '0;
        @(negedge clk);

        for (int i = 0; i < 6; i++) begin
            run_txn(vecs[i].mask, vecs[i].grant, vecs[i].mode, vecs[i].x0, vecs[i].y0,
                    vecs[i].z0, vecs[i].delay, $sformatf("vec%0d", i));
        end

        reset_dut();
        for (int n = 0; n < 5; n++) begin
            run_txn(4'hF, fair_order[n], 1'($urandom), 20'($urandom), 20'($urandom),
                    20'($urandom), 0, $sformatf("fair%0d", n));
        end

        for (int n = 0; n < 30; n++) begin
            mask = NR'($urandom_range(1, 15));
            g    = rr_pick(mask, m_ptr);
            run_txn(mask, g, 1'($urandom), 20'($urandom), 20'($urandom), 20'($urandom),
                    $urandom_range(0, 3), $sformatf("rand%0d", n));
        end

        // Asynchronous reset while the engine is running: nothing from that request may surface.
        scramble_ops();
        req_valid = 4'b0010;
        @(negedge clk);
        req_valid = '0;
        repeat (6) @(negedge clk);
        reset     = 1'b0;
        req_valid = '1;
        #1;
        chk("midrun eng outs", 128'({eng_start, eng_mode, eng_x0, eng_y0, eng_z0}), 128'(0));
        chk("midrun rsp outs", 128'({rsp_valid, rsp_id, rsp_x, rsp_y, rsp_z, rsp_err}), 128'(0));
        chk("midrun req_ready", 128'(req_ready), 128'(0));
        @(negedge clk);
        reset     = 1'b1;
        req_valid = '0;
        m_ptr     = 0;
        seen      = 0;
        repeat (30) begin
            @(negedge clk);
            if (rsp_valid) seen = 1;
        end
        chk("midrun no stale rsp", 128'(seen), 128'(0));
        run_txn(4'b1000, 3, 1'b0, 20'h31415, 20'h92653, 20'h58979, 1, "post-reset");

        // Engine that never finishes.
        stuck = 1;
        scramble_ops();
        g         = rr_pick(4'b0001, m_ptr);
        req_valid = 4'b0001;
        #1;
        chk("stuck grant", 128'(req_ready), 128'(NR'(1) << g));
        @(negedge clk);
        req_valid = '0;
`ifdef CORDIC_SCHED_TIMEOUT_EN
        k = 1;
        while (!rsp_valid && k < TMO + 20) begin
            @(negedge clk);
            k++;
        end
        chk("timeout latency", 128'(k), 128'(TMO + 3));
        chk("timeout rsp", 128'({rsp_err, rsp_id, rsp_x, rsp_y, rsp_z}), 128'({1'b1, 2'(g), 63'd0}));
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        chk("timeout clear", 128'({rsp_valid, rsp_err}), 128'(0));
`else
        seen = 0;
        repeat (3 * TMO) begin
            @(negedge clk);
            if (rsp_valid) seen = 1;
        end
        chk("no watchdog rsp", 128'(seen), 128'(0));
`endif
        stuck = 0;
        reset_dut();
        run_txn(4'b0100, 2, 1'b1, 20'h0BEEF, 20'hFACE0, 20'h00042, 0, "recover");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL global timeout: got no finish expected finish");
        $fatal(1, "bench timeout");
    end
endmodule
